// File: rtl/microondas_pkg.sv
// Shared encodings for the microwave actuator scheduler: FSM state codes
// as seen on heat_state, and the power-level codes on sel_potencia.
package microondas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_INTERLOCK = 2'd2,
        ST_COOLDOWN  = 2'd3
    } heat_state_e;

    localparam logic [1:0] POT_LOW  = 2'd0;
    localparam logic [1:0] POT_MED  = 2'd1;
    localparam logic [1:0] POT_HIGH = 2'd2;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// clr restarts the count; with en low the count is held.
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = en & (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/magnetron_scheduler.sv
// Turns the controller's cooking level and power selection into magnetron,
// fan and lamp drives: slow duty window, door interlock and fan run-on.
module magnetron_scheduler
    import microondas_pkg::*;
#(
    parameter int TICK_DIV     = 100000000,
    parameter int WINDOW_SEC   = 10,
    parameter int LOW_ON       = 3,
    parameter int MED_ON       = 6,
    parameter int HIGH_ON      = 10,
    parameter int FAN_TAIL_SEC = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       porta,
    input  logic [1:0] sel_potencia,
    output logic       magnetron_en,
    output logic       fan_en,
    output logic       lamp_en,
    output logic       sec_tick,
    output logic [1:0] heat_state
);

    localparam logic [3:0] LOW_D    = 4'(LOW_ON);
    localparam logic [3:0] MED_D    = 4'(MED_ON);
    localparam logic [3:0] HIGH_D   = 4'(HIGH_ON);
    localparam logic [3:0] WIN_LAST = 4'(WINDOW_SEC - 1);
    localparam int TW = (FAN_TAIL_SEC > 1) ? $clog2(FAN_TAIL_SEC + 1) : 1;
    localparam logic [TW-1:0] TAIL_LAST = TW'(FAN_TAIL_SEC - 1);

    function automatic logic [3:0] duty_of(input logic [1:0] sel);
        case (sel)
            POT_LOW: duty_of = LOW_D;
            POT_MED: duty_of = MED_D;
            default: duty_of = HIGH_D;
        endcase
    endfunction

    heat_state_e   state_q, state_d;
    logic [3:0]    win_q, win_d;
    logic [3:0]    duty_q, duty_d;
    logic [TW-1:0] tail_q, tail_d;
    logic          tick;
    logic          tick_en;
    logic          tick_clr;
    logic          fresh_run;
    logic          enter_cool;
    logic          win_wrap;

    // Time only advances in RUN while the door is shut, so a door-open cycle
    // costs no magnetron on-time within the window.
    assign tick_en = ((state_q == ST_RUN) & ~porta) | (state_q == ST_COOLDOWN);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run & ~porta) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (~run)       state_d = ST_COOLDOWN;
                else if (porta) state_d = ST_INTERLOCK;
            end
            ST_INTERLOCK: begin
                if (~run)        state_d = ST_COOLDOWN;
                else if (~porta) state_d = ST_RUN;
            end
            ST_COOLDOWN: begin
                if (run & ~porta)                  state_d = ST_RUN;
                else if (tick & (tail_q == TAIL_LAST)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Resuming from INTERLOCK is deliberately not a fresh start.
    assign fresh_run  = (state_d == ST_RUN) &
                        ((state_q == ST_IDLE) | (state_q == ST_COOLDOWN));
    assign enter_cool = (state_d == ST_COOLDOWN) & (state_q != ST_COOLDOWN);
    assign tick_clr   = fresh_run | enter_cool;
    assign win_wrap   = (state_q == ST_RUN) & tick & (win_q == WIN_LAST);

    always_comb begin
        win_d  = win_q;
        duty_d = duty_q;
        tail_d = tail_q;
        if (fresh_run) begin
            win_d  = '0;
            duty_d = duty_of(sel_potencia);
        end else if (win_wrap) begin
            win_d  = '0;
            duty_d = duty_of(sel_potencia);
        end else if ((state_q == ST_RUN) & tick) begin
            win_d = win_q + 4'd1;
        end
        if (enter_cool) begin
            tail_d = '0;
        end else if ((state_q == ST_COOLDOWN) & tick) begin
            tail_d = tail_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            duty_q  <= HIGH_D;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            duty_q  <= duty_d;
            tail_q  <= tail_d;
        end
    end

    // porta is gated combinationally so the magnetron drops the cycle the door opens.
    assign magnetron_en = (state_q == ST_RUN) & (win_q < duty_q) & ~porta;
    assign fan_en       = (state_q != ST_IDLE);
    assign lamp_en      = (porta & ~reset) | (state_q == ST_RUN) | (state_q == ST_INTERLOCK);
    assign sec_tick     = tick;
    assign heat_state   = state_q;

endmodule
